// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: scanout > game read > buffered game write (optional VRAM_STALL_STATS_EN)
module vram_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 2
) (
  input  logic              CLK_VGA,
  input  logic              RST_VGA,
  input  logic              SCAN_REQ,
  input  logic [ADDR_W-1:0] SCAN_ADDR,
  output logic              SCAN_VALID,
  output logic [DATA_W-1:0] SCAN_DATA,
  input  logic              RD_VALID,
  output logic              RD_READY,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_RVALID,
  output logic [DATA_W-1:0] RD_RDATA,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              FIFO_EMPTY
`ifdef VRAM_STALL_STATS_EN
  ,output logic [15:0]      STALL_CNT
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic                run_q;
  logic [FIFO_AW:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]    rd_ptr_q, rd_ptr_d;
  logic                scan_vld_q, scan_vld_d;
  logic                rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]   fifo_addr_q [DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [DEPTH];

  logic                empty, full, push, pop;
  logic                scan_gnt, rd_gnt;
  logic [FIFO_AW-1:0]  head_idx;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign head_idx = rd_ptr_q[FIFO_AW-1:0];

  // Strict-priority grant; run_q keeps the RAM quiet until the first edge after reset release
  always_comb begin
    scan_gnt  = 1'b0;
    rd_gnt    = 1'b0;
    pop       = 1'b0;
    MEM_EN    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = SCAN_ADDR;
    MEM_WDATA = fifo_data_q[head_idx];
    if (run_q) begin
      if (SCAN_REQ) begin
        scan_gnt = 1'b1;
        MEM_EN   = 1'b1;
      end else if (RD_VALID && empty) begin
        rd_gnt   = 1'b1;
        MEM_EN   = 1'b1;
        MEM_ADDR = RD_ADDR;
      end else if (!empty) begin
        pop      = 1'b1;
        MEM_EN   = 1'b1;
        MEM_WE   = 1'b1;
        MEM_ADDR = fifo_addr_q[head_idx];
      end
    end
  end

  // Writes are held off while a read waits for the drain so the read cannot starve
  assign WR_READY   = run_q && !full && !(RD_VALID && !empty);
  assign push       = WR_VALID && WR_READY;
  assign RD_READY   = rd_gnt;
  assign FIFO_EMPTY = empty;
  assign SCAN_DATA  = MEM_RDATA;
  assign RD_RDATA   = MEM_RDATA;
  assign SCAN_VALID = scan_vld_q;
  assign RD_RVALID  = rd_vld_q;

  // Next-state for pointers and the read-valid pulses
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + {{FIFO_AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + {{FIFO_AW{1'b0}}, 1'b1} : rd_ptr_q;
    scan_vld_d = scan_gnt;
    rd_vld_d   = rd_gnt;
  end

  // Control state, cleared asynchronously
  always_ff @(posedge CLK_VGA or negedge RST_VGA) begin
    if (!RST_VGA) begin
      run_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      scan_vld_q <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      scan_vld_q <= scan_vld_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  // FIFO payload storage; contents are meaningless once the pointers are reset
  always_ff @(posedge CLK_VGA) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[FIFO_AW-1:0]] <= WR_ADDR;
      fifo_data_q[wr_ptr_q[FIFO_AW-1:0]] <= WR_DATA;
    end
  end

`ifdef VRAM_STALL_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles a write was offered but refused
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (WR_VALID && !WR_READY && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register
  always_ff @(posedge CLK_VGA or negedge RST_VGA) begin
    if (!RST_VGA) stall_cnt_q <= 16'd0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_req;
  logic [14:0] scan_addr;
  logic        scan_valid;
  logic [7:0]  scan_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [14:0] rd_addr;
  logic        rd_rvalid;
  logic [7:0]  rd_rdata;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        fifo_empty;
`ifdef VRAM_STALL_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] vmem [1024];

  always #5 clk = ~clk;

  vram_arbiter dut (
    .CLK_VGA(clk), .RST_VGA(rst_n),
    .SCAN_REQ(scan_req), .SCAN_ADDR(scan_addr), .SCAN_VALID(scan_valid), .SCAN_DATA(scan_data),
    .RD_VALID(rd_valid), .RD_READY(rd_ready), .RD_ADDR(rd_addr), .RD_RVALID(rd_rvalid), .RD_RDATA(rd_rdata),
    .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata),
    .FIFO_EMPTY(fifo_empty)
`ifdef VRAM_STALL_STATS_EN
    , .STALL_CNT(stall_cnt)
`endif
  );

  // Behavioural single-port RAM with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en && mem_we) vmem[mem_addr[9:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= vmem[mem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    scan_req = 0; scan_addr = '0; rd_valid = 0; rd_addr = '0;
    wr_valid = 0; wr_addr = '0; wr_data = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) vmem[i] = 8'h00;
    mem_rdata = 8'h00;
    rst_n = 0;
    idle_inputs();

    // Reset state
    #2;
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_fifo_empty", 32'(fifo_empty), 1);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_scan_valid", 32'(scan_valid), 0);
    chk("rst_rd_rvalid", 32'(rd_rvalid), 0);
`ifdef VRAM_STALL_STATS_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
    tick();
    @(negedge clk); #1;
    rst_n = 1;
    tick();

    // Idle after release
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_wr_ready", 32'(wr_ready), 1);
      chk("idle_fifo_empty", 32'(fifo_empty), 1);
      chk("idle_mem_en", 32'(mem_en), 0);
      chk("idle_scan_valid", 32'(scan_valid), 0);
      chk("idle_rd_rvalid", 32'(rd_rvalid), 0);
      tick();
    end

    // Two back-to-back writes drain on following cycles
    wr_valid = 1; wr_addr = 15'h0010; wr_data = 8'hAA; #1;
    chk("w2_ready0", 32'(wr_ready), 1);
    chk("w2_mem_en0", 32'(mem_en), 0);
    tick();
    wr_addr = 15'h0011; wr_data = 8'hBB; #1;
    chk("w2_we1", 32'(mem_we), 1);
    chk("w2_addr1", 32'(mem_addr), 32'h10);
    chk("w2_wdata1", 32'(mem_wdata), 32'hAA);
    tick();
    wr_valid = 0; #1;
    chk("w2_we2", 32'(mem_we), 1);
    chk("w2_addr2", 32'(mem_addr), 32'h11);
    chk("w2_wdata2", 32'(mem_wdata), 32'hBB);
    tick();
    #1;
    chk("w2_empty", 32'(fifo_empty), 1);
    chk("w2_idle_en", 32'(mem_en), 0);
    tick();

    // Scan for 6 cycles while 4 writes fill the FIFO
    scan_req = 1; scan_addr = 15'h0010;
    for (int i = 0; i < 6; i++) begin
      wr_valid = (i < 4); wr_addr = 15'h0020 + 15'(i); wr_data = 8'h30 + 8'(i); #1;
      chk("sc_mem_we", 32'(mem_we), 0);
      chk("sc_mem_en", 32'(mem_en), 1);
      chk("sc_wr_ready", 32'(wr_ready), (i < 4) ? 1 : 0);
      if (i > 0) begin
        chk("sc_scan_valid", 32'(scan_valid), 1);
        chk("sc_scan_data", 32'(scan_data), 32'hAA);
      end
      tick();
    end
    scan_req = 0; wr_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dr_we", 32'(mem_we), 1);
      chk("dr_addr", 32'(mem_addr), 32'h20 + i);
      chk("dr_wdata", 32'(mem_wdata), 32'h30 + i);
      chk("dr_wr_ready", 32'(wr_ready), (i == 0) ? 0 : 1);
      tick();
    end
    #1;
    chk("dr_empty", 32'(fifo_empty), 1);
    chk("dr_scan_valid_off", 32'(scan_valid), 0);
    tick();

    // Read-after-write ordering
    wr_valid = 1; wr_addr = 15'h0100; wr_data = 8'h5C; #1;
    chk("raw_push_ready", 32'(wr_ready), 1);
    tick();
    wr_valid = 0; rd_valid = 1; rd_addr = 15'h0100; #1;
    chk("raw_rd_wait", 32'(rd_ready), 0);
    chk("raw_wr_block", 32'(wr_ready), 0);
    chk("raw_drain_we", 32'(mem_we), 1);
    chk("raw_drain_addr", 32'(mem_addr), 32'h100);
    tick();
    #1;
    chk("raw_rd_ready", 32'(rd_ready), 1);
    chk("raw_rd_we", 32'(mem_we), 0);
    chk("raw_rd_addr", 32'(mem_addr), 32'h100);
    tick();
    rd_valid = 0; #1;
    chk("raw_rvalid", 32'(rd_rvalid), 1);
    chk("raw_rdata", 32'(rd_rdata), 32'h5C);
    tick();

    // Scan and read in the same cycle
    scan_req = 1; scan_addr = 15'h0011; rd_valid = 1; rd_addr = 15'h0010; #1;
    chk("sr_rd_ready0", 32'(rd_ready), 0);
    chk("sr_addr0", 32'(mem_addr), 32'h11);
    tick();
    scan_req = 0; #1;
    chk("sr_scan_valid", 32'(scan_valid), 1);
    chk("sr_scan_data", 32'(scan_data), 32'hBB);
    chk("sr_rd_ready1", 32'(rd_ready), 1);
    chk("sr_addr1", 32'(mem_addr), 32'h10);
    tick();
    rd_valid = 0; #1;
    chk("sr_rvalid", 32'(rd_rvalid), 1);
    chk("sr_rdata", 32'(rd_rdata), 32'hAA);
    chk("sr_scan_valid_off", 32'(scan_valid), 0);
    tick();

    // Reset with three entries buffered
    scan_req = 1; scan_addr = 15'h0000;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_addr = 15'h0040 + 15'(i); wr_data = 8'h70 + 8'(i);
      tick();
    end
    wr_valid = 0; #1;
    chk("mr_pre_empty", 32'(fifo_empty), 0);
    chk("mr_pre_scan_valid", 32'(scan_valid), 1);
    rst_n = 0; #1;
    chk("mr_empty", 32'(fifo_empty), 1);
    chk("mr_scan_valid", 32'(scan_valid), 0);
    chk("mr_mem_en", 32'(mem_en), 0);
    chk("mr_wr_ready", 32'(wr_ready), 0);
    idle_inputs();
    tick();
    tick();
    @(negedge clk); #1;
    rst_n = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("mr_post_we", 32'(mem_we), 0);
      chk("mr_post_empty", 32'(fifo_empty), 1);
      tick();
    end
    chk("mr_vmem_40", 32'(vmem[10'h040]), 0);
    chk("mr_vmem_42", 32'(vmem[10'h042]), 0);
`ifdef VRAM_STALL_STATS_EN
    chk("mr_stall_cnt", 32'(stall_cnt), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
